lpm_fifo_dc_wrctl: RTL and testbench

Write-side pointer controller for the dual-clock FIFO. It sequences writes into the FIFO RAM: it generates the write address and write enable, and keeps the binary and Gray write pointers. It derives `wrfull`, `wralmostfull` and `wrusedw` from the read pointer, which arrives already synchronized into the write clock domain through an `lpm_fifo_dc_dffpipe`. Its registered Gray write pointer is the source for the matching synchronizer pipe into the read domain.

---
 rtl/lpm_fifo_dc_wrctl.sv | 61 ++++++
 tb/tb_lpm_fifo_dc_wrctl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lpm_fifo_dc_wrctl.sv
// Write-side pointer controller for the dual-clock FIFO.
// Keeps binary/Gray write pointers and derives full/usedw from the synced read pointer.
module lpm_fifo_dc_wrctl #(
    parameter int lpm_widthu        = 4,
    parameter int lpm_almostfull    = 12,
    parameter     overflow_checking = "ON"
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  wrreq,
    input  logic [lpm_widthu:0]   rdptr_gray_sync,
    output logic                  wren,
    output logic [lpm_widthu-1:0] wraddr,
    output logic [lpm_widthu:0]   wrptr_gray,
    output logic                  wrfull,
    output logic                  wralmostfull,
    output logic [lpm_widthu:0]   wrusedw,
    output logic                  wroverflow
);

    localparam int W = lpm_widthu;
    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};
    localparam logic [W:0] AF   = (W+1)'(lpm_almostfull);
    localparam bit CHK = (overflow_checking == "ON");

    logic [W:0] wrptr_bin;
    logic [W:0] rdptr_bin;
    logic [W:0] next_bin;

    // Each binary bit is the XOR of all Gray bits at and above it
    always_comb begin
        rdptr_bin[W] = rdptr_gray_sync[W];
        for (int n = W - 1; n >= 0; n--) begin
            rdptr_bin[n] = rdptr_bin[n+1] ^ rdptr_gray_sync[n];
        end
    end

    assign wrusedw      = wrptr_bin - rdptr_bin;
    assign wrfull       = (wrusedw == FULL);
    assign wralmostfull = (wrusedw >= AF);
    assign wren         = CHK ? (wrreq & ~wrfull) : wrreq;
    assign wraddr       = wrptr_bin[W-1:0];
    assign next_bin     = wrptr_bin + 1'b1;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wrptr_bin  <= '0;
            wrptr_gray <= '0;
            wroverflow <= 1'b0;
        end else begin
            if (wren) begin
                wrptr_bin  <= next_bin;
                wrptr_gray <= next_bin ^ (next_bin >> 1);
            end
            if (wrreq & wrfull) begin
                wroverflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lpm_fifo_dc_wrctl.sv
// Directed testbench for lpm_fifo_dc_wrctl (depth 16, almost-full 12).
// Inputs change #1 after posedge; outputs are checked before the next edge.
module tb_lpm_fifo_dc_wrctl;

    logic       clock;
    logic       aclr;
    logic       wrreq;
    logic [4:0] rdptr_gray_sync;
    logic       wren;
    logic [3:0] wraddr;
    logic [4:0] wrptr_gray;
    logic       wrfull;
    logic       wralmostfull;
    logic [4:0] wrusedw;
    logic       wroverflow;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-written Gray sequence for pointer values 0..16
    logic [4:0] gray_tab [0:16] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00010,
        5'b00110, 5'b00111, 5'b00101, 5'b00100,
        5'b01100, 5'b01101, 5'b01111, 5'b01110,
        5'b01010, 5'b01011, 5'b01001, 5'b01000,
        5'b11000
    };

    lpm_fifo_dc_wrctl #(
        .lpm_widthu(4),
        .lpm_almostfull(12),
        .overflow_checking("ON")
    ) dut (
        .clock(clock),
        .aclr(aclr),
        .wrreq(wrreq),
        .rdptr_gray_sync(rdptr_gray_sync),
        .wren(wren),
        .wraddr(wraddr),
        .wrptr_gray(wrptr_gray),
        .wrfull(wrfull),
        .wralmostfull(wralmostfull),
        .wrusedw(wrusedw),
        .wroverflow(wroverflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [4:0] ptr;

    initial begin
        aclr = 1'b1;
        wrreq = 1'b0;
        rdptr_gray_sync = 5'd0;
        #2;
        check("rst_wraddr", wraddr, 0);
        check("rst_gray", wrptr_gray, 0);
        check("rst_usedw", wrusedw, 0);
        check("rst_full", wrfull, 0);
        check("rst_af", wralmostfull, 0);
        check("rst_ovf", wroverflow, 0);
        check("rst_wren0", wren, 0);
        wrreq = 1'b1;
        #1;
        check("rst_wren1", wren, 1);
        tick();
        check("rst_hold", wraddr, 0);
        wrreq = 1'b0;
        aclr = 1'b0;
        tick();
        tick();
        check("idle_addr", wraddr, 0);
        check("idle_usedw", wrusedw, 0);

        // Fill 16 words with the reader parked at 0
        for (int i = 0; i < 16; i++) begin
            wrreq = 1'b1;
            #1;
            check("fill_wren", wren, 1);
            check("fill_addr", wraddr, i);
            check("fill_gray", wrptr_gray, gray_tab[i]);
            tick();
            check("fill_usedw", wrusedw, i + 1);
            check("fill_af", wralmostfull, (i + 1 >= 12) ? 1 : 0);
            check("fill_full", wrfull, (i == 15) ? 1 : 0);
        end
        check("full_gray", wrptr_gray, gray_tab[16]);

        // Overflow attempt while full
        check("ovf_wren", wren, 0);
        tick();
        check("ovf_flag", wroverflow, 1);
        check("ovf_gray", wrptr_gray, 5'b11000);
        check("ovf_usedw", wrusedw, 16);
        wrreq = 1'b0;
        tick();
        check("ovf_sticky", wroverflow, 1);

        // Reader advances to 5, then jumps to 16
        rdptr_gray_sync = 5'b00111;
        tick();
        check("rd5_usedw", wrusedw, 11);
        check("rd5_full", wrfull, 0);
        check("rd5_af", wralmostfull, 0);
        rdptr_gray_sync = 5'b11000;
        tick();
        check("rd16_usedw", wrusedw, 0);
        check("rd16_full", wrfull, 0);

        // 40 writes with the reader trailing by two
        ptr = 5'd16;
        rdptr_gray_sync = gray(ptr - 5'd2);
        for (int i = 0; i < 40; i++) begin
            wrreq = 1'b1;
            #1;
            check("wrap_addr", wraddr, ptr[3:0]);
            check("wrap_gray", wrptr_gray, gray(ptr));
            tick();
            ptr = ptr + 5'd1;
            rdptr_gray_sync = gray(ptr - 5'd2);
            #1;
            check("wrap_usedw", wrusedw, 2);
            check("wrap_full", wrfull, 0);
        end
        check("wrap_end", wrptr_gray, gray(5'd24));

        // Reset in the middle of a fill
        wrreq = 1'b0;
        rdptr_gray_sync = gray(ptr);
        tick();
        for (int i = 0; i < 7; i++) begin
            wrreq = 1'b1;
            tick();
        end
        check("mid_usedw", wrusedw, 7);
        #2;
        aclr = 1'b1;
        rdptr_gray_sync = 5'd0;
        #1;
        check("mid_addr", wraddr, 0);
        check("mid_gray", wrptr_gray, 0);
        check("mid_usedw0", wrusedw, 0);
        check("mid_ovf", wroverflow, 0);
        tick();
        check("mid_hold", wraddr, 0);
        aclr = 1'b0;
        #1;
        check("res_addr0", wraddr, 0);
        check("res_wren", wren, 1);
        tick();
        check("res_addr1", wraddr, 1);
        check("res_gray1", wrptr_gray, 5'b00001);
        check("res_usedw", wrusedw, 1);
        wrreq = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
